regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
Issue-side hazard controller and write-port scheduler for the 32 x 32-bit register file (x0 hardwired zero, one write port, write occurs whenever write address != 0). Tracks a busy bit per architectural register for in-flight producers and stalls issue on RAW/WAW hazards. Arbitrates the single write port between the ALU and memory writeback sources with round-robin on conflict. Sits between decode/issue and the register file.

Parameters:
DATA_W, 32, writeback data width
MAX_INFLIGHT, 4, max simultaneously busy registers; range 1..31

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
issue_valid  in  1  decoded instruction presented
issue_ready  out  1  instruction may issue this cycle (combinational)
issue_rs1  in  5  source 1 index
issue_rs2  in  5  source 2 index
issue_rd  in  5  destination index
issue_uses_rs1  in  1  rs1 read by instruction
issue_uses_rs2  in  1  rs2 read by instruction
issue_writes_rd  in  1  instruction writes rd
alu_wb_valid  in  1  ALU result available
alu_wb_ready  out  1  ALU result accepted this cycle
alu_wb_rd  in  5  ALU destination
alu_wb_data  in  DATA_W  ALU result
mem_wb_valid  in  1  load result available
mem_wb_ready  out  1  load result accepted this cycle
mem_wb_rd  in  5  load destination
mem_wb_data  in  DATA_W  load result
reg_wr_addr  out  5  register file write address; 0 = no write
reg_wr_data  out  DATA_W  register file write data
busy_count  out  3  number of busy registers (registered; width ceil(log2(MAX_INFLIGHT+1)))
wb_error  out  1  sticky: writeback to a non-busy nonzero register

Behaviour:
- State: busy[31:1] (busy[0] constant 0), busy_count, rr_ptr (0=ALU next on conflict, 1=MEM), wb_error.
- Reset (async, any cycle incl. mid-transfer): busy=0, busy_count=0, rr_ptr=0, wb_error=0; all in-flight tracking dropped. Outputs during reset: issue_ready per cleared state, reg_wr_addr driven from grant logic (0 if no wb valid).
- issue_ready = !(uses_rs1 & busy[rs1]) & !(uses_rs2 & busy[rs2]) & !(writes_rd & busy[rd]) & !(writes_rd & rd!=0 & busy_count==MAX_INFLIGHT).
- Issue fire = issue_valid & issue_ready. If writes_rd & rd!=0: busy[rd] set, busy_count+1, visible next cycle. rd=0 or !writes_rd: no state change.
- Writeback grant (combinational): only one valid -> granted. Both valid -> rr_ptr source granted; rr_ptr flips to the other source on the clock edge after a conflict grant. Non-conflict grants leave rr_ptr unchanged. Ungranted source sees ready=0 and must hold.
- Granted source drives reg_wr_addr/reg_wr_data same cycle (zero latency). No grant: reg_wr_addr=0, reg_wr_data=0.
- Wb fire with rd!=0: busy[rd] cleared, busy_count-1, visible next cycle. If busy[rd] already 0: write still performed, count unchanged, wb_error set (sticky until reset).
- Wb with rd=0: accepted, reg_wr_addr=0, no state change.
- Same-cycle issue set and wb clear: applied independently; busy_count net unchanged. Same rd cannot coincide (issue would stall on busy rd) except when wb targets a non-busy rd: set wins, wb_error set.
- busy_count never wraps; saturation prevented by issue stall.

Optional Feature:
SCOREBOARD_BYPASS_EN: when defined, the register being cleared by this cycle's wb fire is treated as not busy by issue_ready in the same cycle (one cycle earlier issue), and the count-full check uses busy_count minus that clear. When undefined, clears affect issue_ready only from the next cycle.

Test Plan:
- Reset, issue rd=5 writes_rd=1 -> next cycle busy_count=1; issue rs1=5 uses_rs1=1 -> issue_ready=0 until alu wb rd=5 fires, then ready=1 the following cycle (same cycle with SCOREBOARD_BYPASS_EN).
- Both wb valid (alu rd=3 data=0x11, mem rd=4 data=0x22) after reset -> cycle 0 reg_wr_addr=3 data=0x11, mem_wb_ready=0; cycle 1 reg_wr_addr=4 data=0x22; rr_ptr then 0.
- Issue 4 writers rd=1..4 with MAX_INFLIGHT=4 -> busy_count=4; writer rd=6 stalled; non-writer with unrelated sources issues.
- Issue rd=0 writes_rd=1, then wb rd=0 -> busy_count stays 0, reg_wr_addr=0, wb_error=0.
- Wb rd=9 with busy[9]=0 -> reg_wr_addr=9 that cycle, wb_error=1 sticky, busy_count unchanged.
- Assert reset mid-cycle with busy_count=3 -> outputs clear asynchronously, busy_count=0, wb_error=0 before next clock edge.

Source files
------------

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scoreboard
// Description : Issue-side RAW/WAW hazard scoreboard and round-robin write-port
//               scheduler (ALU vs. memory writeback) for a 32 x 32 register file.
//               Optional macro SCOREBOARD_BYPASS_EN lets a same-cycle writeback
//               clear unblock issue one cycle earlier.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard #(
  parameter int DATA_W       = 32,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               issue_valid,
  output logic                               issue_ready,
  input  logic [4:0]                         issue_rs1,
  input  logic [4:0]                         issue_rs2,
  input  logic [4:0]                         issue_rd,
  input  logic                               issue_uses_rs1,
  input  logic                               issue_uses_rs2,
  input  logic                               issue_writes_rd,
  input  logic                               alu_wb_valid,
  output logic                               alu_wb_ready,
  input  logic [4:0]                         alu_wb_rd,
  input  logic [DATA_W-1:0]                  alu_wb_data,
  input  logic                               mem_wb_valid,
  output logic                               mem_wb_ready,
  input  logic [4:0]                         mem_wb_rd,
  input  logic [DATA_W-1:0]                  mem_wb_data,
  output logic [4:0]                         reg_wr_addr,
  output logic [DATA_W-1:0]                  reg_wr_data,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]  busy_count,
  output logic                               wb_error
);

  localparam int               CNT_W   = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

  logic [31:0]      busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rr_q, rr_d;
  logic             err_q, err_d;

  logic             w_conflict;
  logic             w_grant_alu;
  logic             w_grant_mem;
  logic [4:0]       w_wb_rd;
  logic             w_wb_nz;
  logic             w_clr_hit;
  logic             w_clr_miss;
  logic [31:0]      w_clr_vec;
  logic [31:0]      w_busy_view;
  logic [CNT_W-1:0] w_cnt_view;
  logic             w_issue_fire;
  logic             w_set;
  logic [31:0]      w_set_vec;

  // rr_q == 0 favours the ALU on a conflict, 1 favours the memory port
  assign w_conflict  = alu_wb_valid & mem_wb_valid;
  assign w_grant_alu = alu_wb_valid & (~mem_wb_valid | ~rr_q);
  assign w_grant_mem = mem_wb_valid & (~alu_wb_valid | rr_q);

  assign w_wb_rd    = w_grant_alu ? alu_wb_rd : (w_grant_mem ? mem_wb_rd : 5'd0);
  assign w_wb_nz    = (w_wb_rd != 5'd0);
  assign w_clr_hit  = w_wb_nz & busy_q[w_wb_rd];
  assign w_clr_miss = w_wb_nz & ~busy_q[w_wb_rd];
  assign w_clr_vec  = w_clr_hit ? (32'd1 << w_wb_rd) : 32'd0;

`ifdef SCOREBOARD_BYPASS_EN
  assign w_busy_view = busy_q & ~w_clr_vec;
  assign w_cnt_view  = cnt_q - CNT_W'(w_clr_hit);
`else
  assign w_busy_view = busy_q;
  assign w_cnt_view  = cnt_q;
`endif

  assign issue_ready = ~(issue_uses_rs1 & w_busy_view[issue_rs1])
                     & ~(issue_uses_rs2 & w_busy_view[issue_rs2])
                     & ~(issue_writes_rd & w_busy_view[issue_rd])
                     & ~(issue_writes_rd & (issue_rd != 5'd0) & (w_cnt_view == MAX_CNT));

  assign w_issue_fire = issue_valid & issue_ready;
  assign w_set        = w_issue_fire & issue_writes_rd & (issue_rd != 5'd0);
  assign w_set_vec    = w_set ? (32'd1 << issue_rd) : 32'd0;

  // Set is applied after clear so an issue to the same rd keeps it busy
  assign busy_d = ((busy_q & ~w_clr_vec) | w_set_vec) & ~32'd1;
  assign cnt_d  = cnt_q + CNT_W'(w_set) - CNT_W'(w_clr_hit);
  assign rr_d   = w_conflict ? ~rr_q : rr_q;
  assign err_d  = err_q | w_clr_miss;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q <= 32'd0;
      cnt_q  <= '0;
      rr_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      rr_q   <= rr_d;
      err_q  <= err_d;
    end
  end

  assign alu_wb_ready = w_grant_alu;
  assign mem_wb_ready = w_grant_mem;
  assign reg_wr_addr  = w_wb_rd;
  assign reg_wr_data  = w_grant_alu ? alu_wb_data
                      : (w_grant_mem ? mem_wb_data : {DATA_W{1'b0}});
  assign busy_count   = cnt_q;
  assign wb_error     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_scoreboard
// Description : Self-checking bench for regfile_scoreboard: directed vector
//               table, mid-cycle reset sequence, randomized reference-model run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_scoreboard;

  localparam int DATA_W       = 32;
  localparam int MAX_INFLIGHT = 4;
`ifdef SCOREBOARD_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        issue_valid, issue_ready;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd;
  logic        issue_uses_rs1, issue_uses_rs2, issue_writes_rd;
  logic        alu_wb_valid, alu_wb_ready;
  logic [4:0]  alu_wb_rd;
  logic [31:0] alu_wb_data;
  logic        mem_wb_valid, mem_wb_ready;
  logic [4:0]  mem_wb_rd;
  logic [31:0] mem_wb_data;
  logic [4:0]  reg_wr_addr;
  logic [31:0] reg_wr_data;
  logic [2:0]  busy_count;
  logic        wb_error;

  always #5 clock = ~clock;

  regfile_scoreboard #(.DATA_W(DATA_W), .MAX_INFLIGHT(MAX_INFLIGHT)) dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
    .issue_uses_rs1(issue_uses_rs1), .issue_uses_rs2(issue_uses_rs2),
    .issue_writes_rd(issue_writes_rd),
    .alu_wb_valid(alu_wb_valid), .alu_wb_ready(alu_wb_ready),
    .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
    .mem_wb_valid(mem_wb_valid), .mem_wb_ready(mem_wb_ready),
    .mem_wb_rd(mem_wb_rd), .mem_wb_data(mem_wb_data),
    .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
    .busy_count(busy_count), .wb_error(wb_error)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic iv; logic [4:0] rs1, rs2, rd; logic u1, u2, wr;
    logic av; logic [4:0] ard; logic [31:0] ad;
    logic mv; logic [4:0] mrd; logic [31:0] md;
    logic e_rdy, e_ar, e_mr; logic [4:0] e_wa; logic [31:0] e_wd;
    logic [2:0] e_cnt; logic e_err;
  } vec_t;

  function automatic vec_t mk(int iv, int rs1, int rs2, int rd, int u1, int u2, int wr,
                              int av, int ard, int ad, int mv, int mrd, int md,
                              int e_rdy, int e_ar, int e_mr, int e_wa, int e_wd,
                              int e_cnt, int e_err);
    vec_t v;
    v.iv = 1'(iv); v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.rd = 5'(rd);
    v.u1 = 1'(u1); v.u2 = 1'(u2); v.wr = 1'(wr);
    v.av = 1'(av); v.ard = 5'(ard); v.ad = 32'(ad);
    v.mv = 1'(mv); v.mrd = 5'(mrd); v.md = 32'(md);
    v.e_rdy = 1'(e_rdy); v.e_ar = 1'(e_ar); v.e_mr = 1'(e_mr);
    v.e_wa = 5'(e_wa); v.e_wd = 32'(e_wd); v.e_cnt = 3'(e_cnt); v.e_err = 1'(e_err);
    return v;
  endfunction

  task automatic idle_inputs();
    issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
    issue_uses_rs1 = 0; issue_uses_rs2 = 0; issue_writes_rd = 0;
    alu_wb_valid = 0; alu_wb_rd = 0; alu_wb_data = 0;
    mem_wb_valid = 0; mem_wb_rd = 0; mem_wb_data = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic drive_issue(input int rs1, input int rs2, input int rd,
                             input int u1, input int u2, input int wr);
    issue_valid = 1; issue_rs1 = 5'(rs1); issue_rs2 = 5'(rs2); issue_rd = 5'(rd);
    issue_uses_rs1 = 1'(u1); issue_uses_rs2 = 1'(u2); issue_writes_rd = 1'(wr);
  endtask

  // Reference model state
  bit         mdl_busy [32];
  int         mdl_cnt;
  bit         mdl_rr, mdl_err;
  bit         ap_pend, mp_pend;
  logic [4:0] ap_rd, mp_rd;
  logic [31:0] ap_dat, mp_dat;

  task automatic model_reset();
    foreach (mdl_busy[r]) mdl_busy[r] = 0;
    mdl_cnt = 0; mdl_rr = 0; mdl_err = 0; ap_pend = 0; mp_pend = 0;
  endtask

  function automatic logic [4:0] pick_wb_rd(input bit other_pend, input logic [4:0] other_rd);
    int cand[$];
    if ($urandom_range(0, 7) == 0) return 5'd0;
    for (int r = 1; r < 32; r++)
      if (mdl_busy[r] && !(other_pend && other_rd == 5'(r))) cand.push_back(r);
    if (cand.size() == 0) return 5'd31;
    return 5'(cand[$urandom_range(0, cand.size() - 1)]);
  endfunction

  task automatic rand_cycle(input int cyc);
    bit   ga, gm, rdy;
    int   clr, ceff;
    bit   beff [32];
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    if (!ap_pend && $urandom_range(0, 2) == 0) begin
      ap_rd = pick_wb_rd(mp_pend, mp_rd);
      if (ap_rd != 5'd31 || mdl_busy[31]) begin ap_pend = 1; ap_dat = $urandom; end
    end
    if (!mp_pend && $urandom_range(0, 2) == 0) begin
      mp_rd = pick_wb_rd(ap_pend, ap_rd);
      if (mp_rd != 5'd31 || mdl_busy[31]) begin mp_pend = 1; mp_dat = $urandom; end
    end
    alu_wb_valid = ap_pend; alu_wb_rd = ap_pend ? ap_rd : 5'd0; alu_wb_data = ap_pend ? ap_dat : 32'd0;
    mem_wb_valid = mp_pend; mem_wb_rd = mp_pend ? mp_rd : 5'd0; mem_wb_data = mp_pend ? mp_dat : 32'd0;
    issue_valid     = 1'($urandom_range(0, 1));
    issue_rs1       = 5'($urandom_range(0, 7));
    issue_rs2       = 5'($urandom_range(0, 7));
    issue_rd        = 5'($urandom_range(0, 7));
    issue_uses_rs1  = 1'($urandom_range(0, 1));
    issue_uses_rs2  = 1'($urandom_range(0, 1));
    issue_writes_rd = ($urandom_range(0, 3) != 0);

    if (ap_pend && mp_pend) begin ga = !mdl_rr; gm = mdl_rr; end
    else begin ga = ap_pend; gm = mp_pend; end
    clr  = ga ? int'(ap_rd) : (gm ? int'(mp_rd) : 0);
    e_wa = 5'(clr);
    e_wd = ga ? ap_dat : (gm ? mp_dat : 32'd0);
    beff = mdl_busy; ceff = mdl_cnt;
    if (BYP != 0 && clr != 0 && mdl_busy[clr]) begin beff[clr] = 0; ceff--; end
    rdy = 1;
    if (issue_uses_rs1 && beff[issue_rs1]) rdy = 0;
    if (issue_uses_rs2 && beff[issue_rs2]) rdy = 0;
    if (issue_writes_rd && beff[issue_rd]) rdy = 0;
    if (issue_writes_rd && issue_rd != 0 && ceff == MAX_INFLIGHT) rdy = 0;

    #2;
    chk($sformatf("rnd%0d issue_ready", cyc), 32'(issue_ready), 32'(rdy));
    chk($sformatf("rnd%0d alu_wb_ready", cyc), 32'(alu_wb_ready), 32'(ga));
    chk($sformatf("rnd%0d mem_wb_ready", cyc), 32'(mem_wb_ready), 32'(gm));
    chk($sformatf("rnd%0d reg_wr_addr", cyc), 32'(reg_wr_addr), 32'(e_wa));
    chk($sformatf("rnd%0d reg_wr_data", cyc), reg_wr_data, e_wd);
    chk($sformatf("rnd%0d busy_count", cyc), 32'(busy_count), 32'(mdl_cnt));
    chk($sformatf("rnd%0d wb_error", cyc), 32'(wb_error), 32'(mdl_err));
    @(posedge clock); #1;

    if (clr != 0) begin
      if (mdl_busy[clr]) begin mdl_busy[clr] = 0; mdl_cnt--; end
      else mdl_err = 1;
    end
    if (issue_valid && rdy && issue_writes_rd && issue_rd != 0) begin
      mdl_busy[issue_rd] = 1; mdl_cnt++;
    end
    if (ap_pend && mp_pend) mdl_rr = !mdl_rr;
    if (ga) ap_pend = 0;
    if (gm) mp_pend = 0;
  endtask

  vec_t tbl [23];

  initial begin
    // Directed vectors from reset (MAX_INFLIGHT = 4)
    tbl[0]  = mk(1,0,0,5,0,0,1, 0,0,0,     0,0,0,     1,0,0,0,0,     0,0);
    tbl[1]  = mk(1,5,0,0,1,0,0, 0,0,0,     0,0,0,     0,0,0,0,0,     1,0);
    tbl[2]  = mk(1,5,0,0,1,0,0, 1,5,'hAA,  0,0,0,     BYP,1,0,5,'hAA,1,0);
    tbl[3]  = mk(1,5,0,0,1,0,0, 0,0,0,     0,0,0,     1,0,0,0,0,     0,0);
    tbl[4]  = mk(1,0,0,3,0,0,1, 0,0,0,     0,0,0,     1,0,0,0,0,     0,0);
    tbl[5]  = mk(1,0,0,4,0,0,1, 0,0,0,     0,0,0,     1,0,0,0,0,     1,0);
    tbl[6]  = mk(0,0,0,0,0,0,0, 1,3,'h11,  1,4,'h22,  1,1,0,3,'h11,  2,0);
    tbl[7]  = mk(0,0,0,0,0,0,0, 1,0,'h33,  1,4,'h22,  1,0,1,4,'h22,  1,0);
    tbl[8]  = mk(0,0,0,0,0,0,0, 1,0,'h33,  1,0,'h44,  1,1,0,0,'h33,  0,0);
    tbl[9]  = mk(0,0,0,0,0,0,0, 0,0,0,     1,0,'h44,  1,0,1,0,'h44,  0,0);
    tbl[10] = mk(1,0,0,0,0,0,1, 0,0,0,     0,0,0,     1,0,0,0,0,     0,0);
    tbl[11] = mk(0,0,0,0,0,0,0, 0,0,0,     0,0,0,     1,0,0,0,0,     0,0);
    tbl[12] = mk(1,0,0,1,0,0,1, 0,0,0,     0,0,0,     1,0,0,0,0,     0,0);
    tbl[13] = mk(1,0,0,2,0,0,1, 0,0,0,     0,0,0,     1,0,0,0,0,     1,0);
    tbl[14] = mk(1,0,0,3,0,0,1, 0,0,0,     0,0,0,     1,0,0,0,0,     2,0);
    tbl[15] = mk(1,0,0,4,0,0,1, 0,0,0,     0,0,0,     1,0,0,0,0,     3,0);
    tbl[16] = mk(1,0,0,6,0,0,1, 0,0,0,     0,0,0,     0,0,0,0,0,     4,0);
    tbl[17] = mk(1,7,8,6,1,1,0, 0,0,0,     0,0,0,     1,0,0,0,0,     4,0);
    tbl[18] = mk(1,0,0,6,0,0,1, 1,1,'h5,   0,0,0,     BYP,1,0,1,'h5, 4,0);
    tbl[19] = mk(1,0,0,6,0,0,1, 0,0,0,     0,0,0,     1-BYP,0,0,0,0, 4-(1-BYP),0);
    tbl[20] = mk(0,0,0,0,0,0,0, 1,9,'h99,  0,0,0,     1,1,0,9,'h99,  4,0);
    tbl[21] = mk(0,0,0,0,0,0,0, 0,0,0,     0,0,0,     1,0,0,0,0,     4,1);
    tbl[22] = mk(0,0,0,0,0,0,0, 0,0,0,     0,0,0,     1,0,0,0,0,     4,1);

    do_reset();
    for (int i = 0; i < 23; i++) begin
      issue_valid = tbl[i].iv; issue_rs1 = tbl[i].rs1; issue_rs2 = tbl[i].rs2;
      issue_rd = tbl[i].rd; issue_uses_rs1 = tbl[i].u1; issue_uses_rs2 = tbl[i].u2;
      issue_writes_rd = tbl[i].wr;
      alu_wb_valid = tbl[i].av; alu_wb_rd = tbl[i].ard; alu_wb_data = tbl[i].ad;
      mem_wb_valid = tbl[i].mv; mem_wb_rd = tbl[i].mrd; mem_wb_data = tbl[i].md;
      #2;
      chk($sformatf("row%0d issue_ready", i), 32'(issue_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("row%0d alu_wb_ready", i), 32'(alu_wb_ready), 32'(tbl[i].e_ar));
      chk($sformatf("row%0d mem_wb_ready", i), 32'(mem_wb_ready), 32'(tbl[i].e_mr));
      chk($sformatf("row%0d reg_wr_addr", i), 32'(reg_wr_addr), 32'(tbl[i].e_wa));
      chk($sformatf("row%0d reg_wr_data", i), reg_wr_data, tbl[i].e_wd);
      chk($sformatf("row%0d busy_count", i), 32'(busy_count), 32'(tbl[i].e_cnt));
      chk($sformatf("row%0d wb_error", i), 32'(wb_error), 32'(tbl[i].e_err));
      @(posedge clock); #1;
    end

    // Asynchronous reset in the middle of a cycle with three busy registers
    do_reset();
    drive_issue(0, 0, 1, 0, 0, 1);
    alu_wb_valid = 1; alu_wb_rd = 5'd9; alu_wb_data = 32'h9;
    @(posedge clock); #1;
    alu_wb_valid = 0;
    drive_issue(0, 0, 2, 0, 0, 1); @(posedge clock); #1;
    drive_issue(0, 0, 3, 0, 0, 1); @(posedge clock); #1;
    drive_issue(1, 0, 0, 1, 0, 0);
    alu_wb_valid = 1; alu_wb_rd = 5'd2; alu_wb_data = 32'h5A;
    #2;
    chk("pre_rst busy_count", 32'(busy_count), 32'd3);
    chk("pre_rst wb_error", 32'(wb_error), 32'd1);
    chk("pre_rst issue_ready", 32'(issue_ready), 32'd0);
    reset = 1'b1;
    #1;
    chk("mid_rst busy_count", 32'(busy_count), 32'd0);
    chk("mid_rst wb_error", 32'(wb_error), 32'd0);
    chk("mid_rst issue_ready", 32'(issue_ready), 32'd1);
    chk("mid_rst reg_wr_addr", 32'(reg_wr_addr), 32'd2);
    chk("mid_rst reg_wr_data", reg_wr_data, 32'h5A);

    // Randomized run against the reference model
    do_reset();
    model_reset();
    for (int c = 0; c < 1500; c++) rand_cycle(c);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
